// File: rtl/csi2_frame_ctrl.sv
// Frame-level controller for the CSI-2 receive path: arms the D-PHY, tracks FS/FE/line packets on one VC.
// Optional frame watchdog built only when CSI2_FRAME_TIMEOUT_EN is defined.
module csi2_frame_ctrl #(
    parameter logic [1:0] VC_ID         = 2'd0,
    parameter int         EXP_LINES     = 1080,
    parameter int         FRAME_TIMEOUT = 1048576
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        clr_err_i,
    input  logic        short_pkt_valid_i,
    input  logic [1:0]  short_pkt_v_channel_i,
    input  logic [5:0]  short_pkt_data_type_i,
    input  logic [15:0] short_pkt_data_field_i,
    input  logic        long_pkt_header_valid_i,
    input  logic [1:0]  long_pkt_v_channel_i,
    input  logic [5:0]  long_pkt_data_type_i,
    input  logic        crc_failed_i,
    output logic        rx_enable_o,
    output logic        frame_active_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic [15:0] frame_num_o,
    output logic [15:0] line_cnt_o,
    output logic [7:0]  crc_err_cnt_o,
    output logic        err_line_cnt_o,
    output logic        err_missing_fe_o,
    output logic        err_timeout_o,
    output logic [1:0]  state_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FRAME = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        stop_pend_q, stop_pend_d;
    logic        short_ok, is_fs, is_fe, is_line, stop_req;
    logic        fs_acc, fe_acc, line_acc, timeout_hit;
    logic [15:0] line_base, line_next;
    logic        err_line_set, err_mfe_set;

    assign state_o  = state_q;
    assign short_ok = short_pkt_valid_i && (short_pkt_v_channel_i == VC_ID);
    assign is_fs    = short_ok && (short_pkt_data_type_i == 6'h00);
    assign is_fe    = short_ok && (short_pkt_data_type_i == 6'h01);
    assign is_line  = long_pkt_header_valid_i && (long_pkt_v_channel_i == VC_ID)
                      && (long_pkt_data_type_i >= 6'h10);
    assign stop_req = stop_i | stop_pend_q;

    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        fs_acc      = 1'b0;
        fe_acc      = 1'b0;
        line_acc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (stop_req) begin
                    state_d = ST_IDLE;
                end else if (is_fs) begin
                    fs_acc   = 1'b1;
                    line_acc = is_line;
                    state_d  = ST_FRAME;
                end
            end
            ST_FRAME: begin
                line_acc = is_line;
                // An FS inside a frame restarts it; the short packet wins over the watchdog.
                if (is_fs) begin
                    fs_acc = 1'b1;
                end else if (is_fe) begin
                    fe_acc  = 1'b1;
                    state_d = stop_req ? ST_IDLE : ST_ARMED;
                end else if (timeout_hit) begin
                    state_d = stop_req ? ST_IDLE : ST_ARMED;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            stop_pend_d = 1'b0;
        end else if (state_q == ST_FRAME && stop_i) begin
            stop_pend_d = 1'b1;
        end

        // Short packet is handled before the same-cycle line header, so FS reloads then the line counts.
        line_base = fs_acc ? 16'd0 : line_cnt_o;
        line_next = (line_acc && line_base != 16'hFFFF) ? line_base + 16'd1 : line_base;
    end

    assign err_line_set = fe_acc && (line_next != 16'(EXP_LINES));
    assign err_mfe_set  = fs_acc && (state_q == ST_FRAME);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= ST_IDLE;
            stop_pend_q      <= 1'b0;
            rx_enable_o      <= 1'b0;
            frame_active_o   <= 1'b0;
            frame_start_o    <= 1'b0;
            frame_end_o      <= 1'b0;
            frame_num_o      <= 16'd0;
            line_cnt_o       <= 16'd0;
            crc_err_cnt_o    <= 8'd0;
            err_line_cnt_o   <= 1'b0;
            err_missing_fe_o <= 1'b0;
        end else begin
            state_q        <= state_d;
            stop_pend_q    <= stop_pend_d;
            rx_enable_o    <= (state_d != ST_IDLE);
            frame_active_o <= (state_d == ST_FRAME);
            frame_start_o  <= fs_acc;
            frame_end_o    <= fe_acc;
            line_cnt_o     <= line_next;
            if (fs_acc) frame_num_o <= short_pkt_data_field_i;

            // A CRC failure in the clearing cycle survives as a count of one.
            if (crc_failed_i) begin
                if (clr_err_i)                   crc_err_cnt_o <= 8'd1;
                else if (crc_err_cnt_o != 8'hFF) crc_err_cnt_o <= crc_err_cnt_o + 8'd1;
            end else if (clr_err_i) begin
                crc_err_cnt_o <= 8'd0;
            end

            err_line_cnt_o   <= err_line_set | (err_line_cnt_o & ~clr_err_i);
            err_missing_fe_o <= err_mfe_set | (err_missing_fe_o & ~clr_err_i);
        end
    end

`ifdef CSI2_FRAME_TIMEOUT_EN
    localparam int TMR_W = (FRAME_TIMEOUT > 2) ? $clog2(FRAME_TIMEOUT) : 1;

    logic [TMR_W-1:0] idle_cnt_q;
    logic             pkt_seen;

    assign pkt_seen    = short_pkt_valid_i | long_pkt_header_valid_i;
    assign timeout_hit = (state_q == ST_FRAME) && !pkt_seen
                         && (idle_cnt_q == TMR_W'(FRAME_TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idle_cnt_q    <= '0;
            err_timeout_o <= 1'b0;
        end else begin
            if (state_q != ST_FRAME || pkt_seen || timeout_hit) idle_cnt_q <= '0;
            else                                                 idle_cnt_q <= idle_cnt_q + 1'b1;
            err_timeout_o <= timeout_hit | (err_timeout_o & ~clr_err_i);
        end
    end
`else
    assign timeout_hit   = 1'b0;
    // Watchdog absent: flag is constant zero (parameter kept for interface compatibility).
    assign err_timeout_o = (FRAME_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_csi2_frame_ctrl.sv
// Bench for csi2_frame_ctrl: table-driven vectors through an expected queue, plus multi-cycle sequences.
module tb_csi2_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, stop, clr, sv, lv, crc;
    logic [1:0]  svc, lvc;
    logic [5:0]  sdt, ldt;
    logic [15:0] sfield;

    logic        s_rx, s_act, s_fs, s_fe, s_el, s_em, s_et;
    logic [15:0] s_fnum, s_lcnt;
    logic [7:0]  s_crc;
    logic [1:0]  s_st;
    logic        b_rx, b_act, b_fs, b_fe, b_el, b_em, b_et;
    logic [15:0] b_fnum, b_lcnt;
    logic [7:0]  b_crc;
    logic [1:0]  b_st;

    int checks = 0;
    int errors = 0;
    logic [48:0] exp_q[$];

    csi2_frame_ctrl #(.VC_ID(2'd0), .EXP_LINES(4), .FRAME_TIMEOUT(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .clr_err_i(clr),
        .short_pkt_valid_i(sv), .short_pkt_v_channel_i(svc), .short_pkt_data_type_i(sdt),
        .short_pkt_data_field_i(sfield), .long_pkt_header_valid_i(lv),
        .long_pkt_v_channel_i(lvc), .long_pkt_data_type_i(ldt), .crc_failed_i(crc),
        .rx_enable_o(s_rx), .frame_active_o(s_act), .frame_start_o(s_fs), .frame_end_o(s_fe),
        .frame_num_o(s_fnum), .line_cnt_o(s_lcnt), .crc_err_cnt_o(s_crc),
        .err_line_cnt_o(s_el), .err_missing_fe_o(s_em), .err_timeout_o(s_et), .state_o(s_st)
    );

    csi2_frame_ctrl dut_big (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .clr_err_i(clr),
        .short_pkt_valid_i(sv), .short_pkt_v_channel_i(svc), .short_pkt_data_type_i(sdt),
        .short_pkt_data_field_i(sfield), .long_pkt_header_valid_i(lv),
        .long_pkt_v_channel_i(lvc), .long_pkt_data_type_i(ldt), .crc_failed_i(crc),
        .rx_enable_o(b_rx), .frame_active_o(b_act), .frame_start_o(b_fs), .frame_end_o(b_fe),
        .frame_num_o(b_fnum), .line_cnt_o(b_lcnt), .crc_err_cnt_o(b_crc),
        .err_line_cnt_o(b_el), .err_missing_fe_o(b_em), .err_timeout_o(b_et), .state_o(b_st)
    );

    typedef struct {
        logic        start, stop, clr, sv;
        logic [1:0]  svc;
        logic [5:0]  sdt;
        logic [15:0] field;
        logic        lv;
        logic [1:0]  lvc;
        logic [5:0]  ldt;
        logic        crc;
        logic [48:0] exp;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [48:0] e(input logic rx, input logic act, input logic fs, input logic fe,
                                      input logic [15:0] fnum, input logic [15:0] lcnt,
                                      input logic [7:0] c, input logic [2:0] errs, input logic [1:0] st);
        return {rx, act, fs, fe, fnum, lcnt, c, errs, st};
    endfunction

    function automatic logic [48:0] s_obs();
        return {s_rx, s_act, s_fs, s_fe, s_fnum, s_lcnt, s_crc, s_el, s_em, s_et, s_st};
    endfunction

    function automatic logic [48:0] b_obs();
        return {b_rx, b_act, b_fs, b_fe, b_fnum, b_lcnt, b_crc, b_el, b_em, b_et, b_st};
    endfunction

    task automatic row(input int i, input logic st_, input logic sp_, input logic cl_,
                       input logic sv_, input logic [1:0] svc_, input logic [5:0] sdt_,
                       input logic [15:0] f_, input logic lv_, input logic [1:0] lvc_,
                       input logic [5:0] ldt_, input logic crc_, input logic [48:0] ex);
        tbl[i] = '{st_, sp_, cl_, sv_, svc_, sdt_, f_, lv_, lvc_, ldt_, crc_, ex};
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        start = 1'b0; stop = 1'b0; clr = 1'b0; sv = 1'b0; svc = 2'd0; sdt = 6'd0;
        sfield = 16'd0; lv = 1'b0; lvc = 2'd0; ldt = 6'd0; crc = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send_short(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] field);
        sv = 1'b1; svc = vc; sdt = dt; sfield = field;
        cyc();
        sv = 1'b0; svc = 2'd0; sdt = 6'd0; sfield = 16'd0;
    endtask

    task automatic send_lines(input int n, input logic [1:0] vc);
        for (int k = 0; k < n; k++) begin
            lv = 1'b1; lvc = vc; ldt = 6'(32'h10 + $urandom_range(0, 47));
            cyc();
        end
        lv = 1'b0; lvc = 2'd0; ldt = 6'd0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        //   i  start stop  clr   sv    svc   sdt    field      lv    lvc   ldt    crc
        row(0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'h00, 16'h0000, 1'b0, 2'd0, 6'h00, 1'b0, e(0,0,0,0,16'h0000,16'd0,8'd0,3'b000,2'd0));
        row(1,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 6'h00, 16'h0000, 1'b0, 2'd0, 6'h00, 1'b0, e(1,0,0,0,16'h0000,16'd0,8'd0,3'b000,2'd1));
        row(2,  1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 6'h00, 16'h0005, 1'b0, 2'd0, 6'h00, 1'b0, e(1,0,0,0,16'h0000,16'd0,8'd0,3'b000,2'd1));
        row(3,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'h00, 16'h0005, 1'b0, 2'd0, 6'h00, 1'b0, e(1,1,1,0,16'h0005,16'd0,8'd0,3'b000,2'd2));
        row(4,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'h00, 16'h0000, 1'b1, 2'd0, 6'h2A, 1'b0, e(1,1,0,0,16'h0005,16'd1,8'd0,3'b000,2'd2));
        row(5,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'h00, 16'h0000, 1'b1, 2'd0, 6'h0F, 1'b0, e(1,1,0,0,16'h0005,16'd1,8'd0,3'b000,2'd2));
        row(6,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'h00, 16'h0000, 1'b1, 2'd1, 6'h2A, 1'b0, e(1,1,0,0,16'h0005,16'd1,8'd0,3'b000,2'd2));
        row(7,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'h05, 16'h0000, 1'b0, 2'd0, 6'h00, 1'b0, e(1,1,0,0,16'h0005,16'd1,8'd0,3'b000,2'd2));
        row(8,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'h00, 16'h0000, 1'b1, 2'd0, 6'h2A, 1'b1, e(1,1,0,0,16'h0005,16'd2,8'd1,3'b000,2'd2));
        row(9,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'h00, 16'h0000, 1'b1, 2'd0, 6'h10, 1'b0, e(1,1,0,0,16'h0005,16'd3,8'd1,3'b000,2'd2));
        row(10, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'h01, 16'h0000, 1'b1, 2'd0, 6'h3F, 1'b0, e(1,0,0,1,16'h0005,16'd4,8'd1,3'b000,2'd1));
        row(11, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 6'h00, 16'h0000, 1'b0, 2'd0, 6'h00, 1'b1, e(1,0,0,0,16'h0005,16'd4,8'd1,3'b000,2'd1));
        row(12, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 6'h00, 16'h0000, 1'b0, 2'd0, 6'h00, 1'b0, e(1,0,0,0,16'h0005,16'd4,8'd0,3'b000,2'd1));
        row(13, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'h00, 16'hBEEF, 1'b1, 2'd0, 6'h2A, 1'b0, e(1,1,1,0,16'hBEEF,16'd1,8'd0,3'b000,2'd2));
        row(14, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'h01, 16'h0000, 1'b0, 2'd0, 6'h00, 1'b0, e(1,0,0,1,16'hBEEF,16'd1,8'd0,3'b100,2'd1));
        row(15, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 6'h00, 16'h0000, 1'b0, 2'd0, 6'h00, 1'b0, e(0,0,0,0,16'hBEEF,16'd1,8'd0,3'b100,2'd0));
        row(16, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 6'h00, 16'h0000, 1'b0, 2'd0, 6'h00, 1'b0, e(0,0,0,0,16'hBEEF,16'd1,8'd0,3'b100,2'd0));
        row(17, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'h00, 16'h0003, 1'b0, 2'd0, 6'h00, 1'b0, e(0,0,0,0,16'hBEEF,16'd1,8'd0,3'b100,2'd0));

        do_reset();
        check("reset_small", 64'(s_obs()), 64'd0);
        check("reset_big", 64'(b_obs()), 64'd0);

        for (int i = 0; i < 18; i++) begin
            start = tbl[i].start; stop = tbl[i].stop; clr = tbl[i].clr;
            sv = tbl[i].sv; svc = tbl[i].svc; sdt = tbl[i].sdt; sfield = tbl[i].field;
            lv = tbl[i].lv; lvc = tbl[i].lvc; ldt = tbl[i].ldt; crc = tbl[i].crc;
            exp_q.push_back(tbl[i].exp);
            cyc();
            check($sformatf("vec%0d", i), 64'(s_obs()), 64'(exp_q.pop_front()));
        end
        clear_in();
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        // Full-size frame on the default instance.
        do_reset();
        start = 1'b1; cyc(); start = 1'b0;
        send_short(2'd0, 6'h00, 16'd7);
        check("big_fs_pulse", 64'(b_fs), 64'd1);
        check("big_fnum", 64'(b_fnum), 64'd7);
        send_lines(1080, 2'd0);
        check("big_fs_one_cycle", 64'(b_fs), 64'd0);
        send_short(2'd0, 6'h01, 16'd0);
        check("big_fe_pulse", 64'(b_fe), 64'd1);
        check("big_lines", 64'(b_lcnt), 64'd1080);
        check("big_errs", 64'({b_el, b_em, b_et}), 64'd0);
        check("big_state_armed", 64'(b_st), 64'd1);
        check("small_err_line", 64'(s_el), 64'd1);
        cyc();
        check("big_fe_one_cycle", 64'(b_fe), 64'd0);
        check("big_lines_hold", 64'(b_lcnt), 64'd1080);

        // Clear, then FS without FE.
        clr = 1'b1; cyc(); clr = 1'b0;
        check("clr_err_line", 64'(s_el), 64'd0);
        send_short(2'd0, 6'h00, 16'd1);
        send_lines(2, 2'd0);
        send_short(2'd0, 6'h00, 16'd9);
        check("mfe_flag", 64'(s_em), 64'd1);
        check("mfe_fnum", 64'(s_fnum), 64'd9);
        check("mfe_lines", 64'(s_lcnt), 64'd0);
        check("mfe_no_fe", 64'(s_fe), 64'd0);
        check("mfe_fs", 64'({s_fs, s_act}), 64'b11);

        // Stop inside a frame waits for FE.
        stop = 1'b1; cyc(); stop = 1'b0;
        check("stop_mid_rx", 64'({s_rx, s_st}), {61'd0, 1'b1, 2'd2});
        send_lines(1, 2'd0);
        repeat (2) cyc();
        check("stop_pend_rx", 64'({s_rx, s_act}), 64'b11);
        send_short(2'd0, 6'h01, 16'd0);
        check("stop_fe", 64'({s_fe, s_rx, s_st}), {60'd0, 1'b1, 1'b0, 2'd0});
        start = 1'b1; cyc(); start = 1'b0;
        check("rearm", 64'({s_rx, s_st}), {61'd0, 1'b1, 2'd1});
        stop = 1'b1; cyc(); stop = 1'b0;
        check("stop_armed", 64'({s_rx, s_st}), 64'd0);

        // Foreign VC traffic leaves everything alone; CRC count saturates.
        start = 1'b1; cyc(); start = 1'b0;
        send_short(2'd1, 6'h00, 16'd33);
        send_lines(3, 2'd1);
        send_short(2'd1, 6'h01, 16'd0);
        check("vc_filter", 64'({s_act, s_fs, s_fe, s_fnum, s_lcnt, s_st}), {44'd0, 3'b000, 16'd9, 16'd1, 2'd1});
        crc = 1'b1;
        repeat (300) cyc();
        crc = 1'b0;
        check("crc_sat_small", 64'(s_crc), 64'd255);
        check("crc_sat_big", 64'(b_crc), 64'd255);

        // Reset in the middle of a frame.
        send_short(2'd0, 6'h00, 16'd4);
        check("pre_rst_active", 64'(s_act), 64'd1);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("rst_mid_frame", 64'(s_obs()), 64'd0);

`ifdef CSI2_FRAME_TIMEOUT_EN
        start = 1'b1; cyc(); start = 1'b0;
        send_short(2'd0, 6'h00, 16'd2);
        repeat (15) cyc();
        check("timeout_not_yet", 64'({s_et, s_act}), 64'b01);
        cyc();
        check("timeout_hit", 64'({s_et, s_act, s_fe, s_st}), {59'd0, 1'b1, 1'b0, 1'b0, 2'd1});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
